// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus SRAM responder: request/response structs,
// access sizes, responder FSM states and the alignment helper.
package dbus_sram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Request fields held across WAIT; also the set compared for stability.
    typedef struct packed {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_lat_t;

    function automatic logic is_misaligned(input logic [2:0] addr, input msize_t size);
        logic [2:0] mask;
        case (size)
            MSIZE1:  mask = 3'b000;
            MSIZE2:  mask = 3'b001;
            MSIZE4:  mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return (addr & mask) != 3'b000;
    endfunction

endpackage

// File: rtl/dbus_sram_responder_sram.sv
// Single-port word SRAM with per-byte write enables: synchronous write,
// asynchronous read. Contents are never reset.
module sram_1rw_be #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [7:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by an on-chip SRAM: accepts one request in IDLE,
// answers with data_ok a fixed LATENCY cycles later, then returns to IDLE.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) * 64'd8;
    // WAIT spans LATENCY-1 cycles so data_ok lands LATENCY cycles after accept.
    localparam logic [3:0]  WAIT_INIT  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    resp_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    dbus_lat_t     req_q, req_d, req_now;
    logic [63:0]   offset;
    logic [AW-1:0] index;
    logic          req_bad;
    logic          mem_we;
    logic [63:0]   mem_rdata;

    assign req_now.addr   = dreq.addr;
    assign req_now.size   = dreq.size;
    assign req_now.strobe = dreq.strobe;
    assign req_now.data   = dreq.data;

    assign offset  = req_q.addr - BASE_ADDR;
    assign index   = offset[AW+2:3];
    assign req_bad = (req_q.addr < BASE_ADDR) || (offset >= SPAN_BYTES)
                     || is_misaligned(req_q.addr[2:0], req_q.size);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    req_d   = req_now;
                    cnt_d   = WAIT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!dreq.valid) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The write is gated by reset so a reset landing on RESP drops the access.
    always_comb begin
        dresp  = '0;
        err    = 1'b0;
        mem_we = 1'b0;
        case (state_q)
            IDLE: dresp.addr_ok = dreq.valid;
            WAIT: err = dreq.valid && (req_now != req_q);
            RESP: begin
                dresp.data_ok = 1'b1;
                dresp.data    = req_bad ? 64'd0 : mem_rdata;
                err           = req_bad;
                mem_we        = reset && !req_bad && (req_q.strobe != 8'h00);
            end
            default: ;
        endcase
    end

    sram_1rw_be #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk_i  (clk),
        .we_i   (mem_we),
        .be_i   (req_q.strobe),
        .addr_i (index),
        .wdata_i(req_q.data),
        .rdata_o(mem_rdata)
    );

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Self-checking bench for dbus_sram_responder: directed scenarios plus a
// randomized run against a word-array reference model.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    dbus_req_t  dreq;
    dbus_resp_t dresp, dresp1, dresp7;
    logic       err, err1, err7;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .err(err)
    );
    dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut_l1 (
        .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp1), .err(err1)
    );
    dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(7), .BASE_ADDR(BASE)) dut_l7 (
        .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp7), .err(err7)
    );

    // Drives one request on the main instance and reports what came back.
    task automatic do_txn(input logic [63:0] a, input msize_t s, input logic [7:0] st,
                          input logic [63:0] d, output int lat, output logic [63:0] rd,
                          output logic errWait, output logic errResp);
        @(negedge clk);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = s;
        dreq.strobe = st;
        dreq.data   = d;
        lat = -1; rd = '0; errWait = 1'b0; errResp = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (dresp.data_ok) begin
                lat = n;
                rd = dresp.data;
                errResp = err;
                dreq.valid = 1'b0;
                break;
            end else if (err) begin
                errWait = 1'b1;
            end
        end
        dreq.valid = 1'b0;
    endtask

    task automatic test_reset();
        dreq = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (dresp !== '0) begin
            errorCount++; $display("[TB] FAIL reset_dresp got %h want 0", dresp);
        end
        checkCount++;
        if (err !== 1'b0) begin
            errorCount++; $display("[TB] FAIL reset_err got %b want 0", err);
        end
        reset = 1'b1;
        @(negedge clk);
        checkCount++;
        if (dresp !== '0) begin
            errorCount++; $display("[TB] FAIL idle_dresp got %h want 0", dresp);
        end
    endtask

    task automatic test_read_after_write();
        int lat; logic [63:0] rd; logic ew, er;
        do_txn(64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, lat, rd, ew, er);
        checkCount++;
        if (lat != 2 || ew || er) begin
            errorCount++; $display("[TB] FAIL raw_write lat %0d err %b/%b want 2 0/0", lat, ew, er);
        end
        do_txn(64'h8000_0010, MSIZE8, 8'h00, 64'h0, lat, rd, ew, er);
        checkCount++;
        if (lat != 2 || ew || er) begin
            errorCount++; $display("[TB] FAIL raw_read lat %0d err %b/%b want 2 0/0", lat, ew, er);
        end
        checkCount++;
        if (rd !== 64'h1122_3344_5566_7788) begin
            errorCount++; $display("[TB] FAIL raw_data got %h want 1122334455667788", rd);
        end
    endtask

    task automatic test_byte_strobe();
        int lat; logic [63:0] rd; logic ew, er;
        do_txn(BASE, MSIZE8, 8'hFF, 64'h0, lat, rd, ew, er);
        do_txn(64'h8000_0002, MSIZE2, 8'h0C, 64'h0000_0000_AABB_0000, lat, rd, ew, er);
        checkCount++;
        if (lat != 2 || er) begin
            errorCount++; $display("[TB] FAIL strobe_write lat %0d err %b want 2 0", lat, er);
        end
        do_txn(BASE, MSIZE8, 8'h00, 64'h0, lat, rd, ew, er);
        checkCount++;
        if (rd !== 64'h0000_0000_AABB_0000) begin
            errorCount++; $display("[TB] FAIL strobe_data got %h want 00000000aabb0000", rd);
        end
    endtask

    task automatic test_errors();
        int lat; logic [63:0] rd; logic ew, er;
        do_txn(64'h8000_7FF8, MSIZE8, 8'hFF, 64'h5555_6666_7777_8888, lat, rd, ew, er);
        do_txn(64'h7FFF_FFF8, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, ew, er);
        checkCount++;
        if (lat != 2 || rd !== 64'h0 || !er || ew) begin
            errorCount++;
            $display("[TB] FAIL oor_resp lat %0d data %h err %b/%b want 2 0 0/1", lat, rd, ew, er);
        end
        do_txn(64'h8000_0003, MSIZE4, 8'h78, 64'h1234_5678_9ABC_DEF0, lat, rd, ew, er);
        checkCount++;
        if (lat != 2 || rd !== 64'h0 || !er || ew) begin
            errorCount++;
            $display("[TB] FAIL misalign_resp lat %0d data %h err %b/%b want 2 0 0/1", lat, rd, ew, er);
        end
        do_txn(BASE, MSIZE8, 8'h00, 64'h0, lat, rd, ew, er);
        checkCount++;
        if (rd !== 64'h0000_0000_AABB_0000 || er) begin
            errorCount++; $display("[TB] FAIL err_word0 got %h err %b want 00000000aabb0000 0", rd, er);
        end
        do_txn(64'h8000_7FF8, MSIZE8, 8'h00, 64'h0, lat, rd, ew, er);
        checkCount++;
        if (rd !== 64'h5555_6666_7777_8888) begin
            errorCount++; $display("[TB] FAIL err_lastword got %h want 5555666677778888", rd);
        end
    endtask

    task automatic test_abort();
        int lat; logic [63:0] rd; logic ew, er; logic okSeen;
        do_txn(BASE + 64'h28, MSIZE8, 8'hFF, 64'hA5A5_0000_1111_2222, lat, rd, ew, er);
        @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = BASE + 64'h28; dreq.size = MSIZE8;
        dreq.strobe = 8'hFF; dreq.data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        dreq.valid = 1'b0;
        okSeen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dresp.data_ok) okSeen = 1'b1;
        end
        checkCount++;
        if (okSeen) begin
            errorCount++; $display("[TB] FAIL abort_dataok got 1 want 0");
        end
        do_txn(BASE + 64'h28, MSIZE8, 8'h00, 64'h0, lat, rd, ew, er);
        checkCount++;
        if (rd !== 64'hA5A5_0000_1111_2222) begin
            errorCount++; $display("[TB] FAIL abort_nowrite got %h want a5a5000011112222", rd);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd; logic ew, er;
        do_txn(BASE + 64'h30, MSIZE8, 8'hFF, 64'h0BAD_F00D_0000_0006, lat, rd, ew, er);
        @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = BASE + 64'h30; dreq.size = MSIZE8;
        dreq.strobe = 8'hFF; dreq.data = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        reset = 1'b0;
        dreq.valid = 1'b0;
        @(negedge clk);
        checkCount++;
        if (dresp !== '0 || err !== 1'b0) begin
            errorCount++; $display("[TB] FAIL midreset_dresp got %h err %b want 0 0", dresp, err);
        end
        reset = 1'b1;
        do_txn(BASE + 64'h30, MSIZE8, 8'h00, 64'h0, lat, rd, ew, er);
        checkCount++;
        if (lat != 2 || rd !== 64'h0BAD_F00D_0000_0006) begin
            errorCount++; $display("[TB] FAIL midreset_after lat %0d data %h want 2 0badf00d00000006", lat, rd);
        end
    endtask

    task automatic test_unstable();
        int lat; logic [63:0] rd; logic ew, er;
        do_txn(BASE + 64'h38, MSIZE8, 8'hFF, 64'h7777_0000_0000_0007, lat, rd, ew, er);
        do_txn(BASE + 64'h40, MSIZE8, 8'hFF, 64'h8888_0000_0000_0008, lat, rd, ew, er);
        @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = BASE + 64'h38; dreq.size = MSIZE8;
        dreq.strobe = 8'h00; dreq.data = 64'h0;
        @(negedge clk);
        dreq.addr = BASE + 64'h40;
        #1;
        checkCount++;
        if (err !== 1'b1) begin
            errorCount++; $display("[TB] FAIL unstable_err got %b want 1", err);
        end
        @(negedge clk);
        checkCount++;
        if (dresp.data_ok !== 1'b1 || dresp.data !== 64'h7777_0000_0000_0007 || err !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL unstable_resp ok %b data %h err %b want 1 7777000000000007 0",
                     dresp.data_ok, dresp.data, err);
        end
        dreq.valid = 1'b0;
    endtask

    task automatic test_latency_sweep();
        int lats[3] = '{1, 2, 7};
        logic got, want;
        repeat (3) @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = BASE; dreq.size = MSIZE8;
        dreq.strobe = 8'h00; dreq.data = 64'h0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                want = (n >= lats[k]) && (((n - lats[k]) % (lats[k] + 1)) == 0);
                got = (k == 0) ? dresp1.data_ok : (k == 1) ? dresp.data_ok : dresp7.data_ok;
                checkCount++;
                if (got !== want) begin
                    errorCount++;
                    $display("[TB] FAIL sweep_L%0d cycle %0d data_ok got %b want %b", lats[k], n, got, want);
                end
            end
        end
        dreq.valid = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] model [16];
        int lat; logic [63:0] rd; logic ew, er;
        logic [63:0] a, d, expData;
        logic [7:0] st;
        msize_t s;
        int idx, off, pick;
        logic bad;
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom};
            do_txn(BASE + 64'(i * 8), MSIZE8, 8'hFF, d, lat, rd, ew, er);
            model[i] = d;
        end
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            off = $urandom_range(0, 7);
            s = msize_t'(3'($urandom_range(0, 3)));
            st = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            d = {$urandom, $urandom};
            if (pick == 0) begin
                a = BASE - 64'(8 * $urandom_range(1, 4));
                s = MSIZE8;
                bad = 1'b1;
            end else if (pick == 1) begin
                a = BASE + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 4));
                s = MSIZE8;
                bad = 1'b1;
            end else begin
                a = BASE + 64'(idx * 8 + off);
                bad = (off % (1 << int'(s))) != 0;
            end
            expData = bad ? 64'h0 : model[idx];
            do_txn(a, s, st, d, lat, rd, ew, er);
            if (!bad) begin
                for (int b = 0; b < 8; b++) begin
                    if (st[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            checkCount++;
            if (lat != 2) begin
                errorCount++; $display("[TB] FAIL rand_lat txn %0d got %0d want 2", t, lat);
            end
            checkCount++;
            if (rd !== expData) begin
                errorCount++; $display("[TB] FAIL rand_data txn %0d addr %h got %h want %h", t, a, rd, expData);
            end
            checkCount++;
            if (er !== bad || ew !== 1'b0) begin
                errorCount++; $display("[TB] FAIL rand_err txn %0d got %b/%b want 0/%b", t, ew, er, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_after_write();
        test_byte_strobe();
        test_errors();
        test_abort();
        test_reset_mid();
        test_unstable();
        test_latency_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
